// File: rtl/rp_pkg.sv
// Shared definitions for the reconfigurable-partition measurement sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rp_pkg;

  localparam int BUS_WIDTH_DEF = 32;  // default width of rp_reg_0 / rp_reg_1
  localparam int GO_DONE_BIT   = 31;  // go (rp_reg_0) and done (rp_reg_1) bit position
  localparam int COUNT_W       = 31;  // window / oscillation count width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RP_RST  = 3'd1,
    ARM     = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    FINISH  = 3'd5,
    ERR     = 3'd6
  } rp_state_e;

endpackage

// File: rtl/rp_done_sync.sv
// Brings the partition done bit into the Clk domain and qualifies it as stable.
// Latency: 2 cycles of synchronizer plus 2 cycles high before done_stable asserts.
// Backpressure: none; clr holds the qualifier off while the sequencer is not waiting.
//
// Ports:
//   Clk, Reset_n  - clock and async active-low reset
//   clr           - forces the stability counter to zero
//   done_async    - raw done bit from the oscillator domain
//   done_stable   - high once the synchronized done has been high 2 consecutive cycles
module rp_done_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic done_async,
  output logic done_stable
);

  logic       sync_1;
  logic       sync_2;
  logic [1:0] hi_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= done_async;
      sync_2 <= sync_1;
    end
  end

  // Any low cycle restarts the qualification, so a single-cycle glitch never
  // reaches done_stable.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_cnt <= 2'd0;
    end else if (clr || !sync_2) begin
      hi_cnt <= 2'd0;
    end else if (hi_cnt != 2'd2) begin
      hi_cnt <= hi_cnt + 2'd1;
    end
  end

  assign done_stable = (hi_cnt == 2'd2);

endmodule

// File: rtl/rp_sequencer.sv
// Runs num_runs measurement runs on the reconfigurable partition and sums the counts.
// Latency per run: RST_CYCLES + 1 + done latency + 2 + 2 + 1 cycles; all outputs registered.
// Backpressure: none; start is only honoured in IDLE and is dropped otherwise.
//
// Ports:
//   Clk, Reset_n      - clock and async active-low reset
//   start             - begin a sequence (IDLE only)
//   window, num_runs  - sample window and run count, latched on an accepted start
//   busy              - sequence in progress, through the result_valid cycle
//   result_valid      - one-cycle end-of-sequence pulse (normal or timeout)
//   result_sum        - sum of captured counts
//   last_count        - count from the most recent completed run
//   timeout_err       - sticky timeout flag, cleared on an accepted start
//   rp_reg_0          - command word to partition {go, window}
//   rp_reg_1          - status word from partition {done, count}
//   rp_reset_n        - partition reset, active-low
module rp_sequencer
  import rp_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int RUNS_W         = 8,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_MARGIN = 1024
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      start,
  input  logic [COUNT_W-1:0]        window,
  input  logic [RUNS_W-1:0]         num_runs,
  output logic                      busy,
  output logic                      result_valid,
  output logic [COUNT_W+RUNS_W-1:0] result_sum,
  output logic [COUNT_W-1:0]        last_count,
  output logic                      timeout_err,
  output logic [BUS_WIDTH-1:0]      rp_reg_0,
  input  logic [BUS_WIDTH-1:0]      rp_reg_1,
  output logic                      rp_reset_n
);

  localparam int SUM_W = COUNT_W + RUNS_W;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  rp_state_e          state;
  rp_state_e          state_d;
  logic [COUNT_W-1:0] win_q;
  logic [RUNS_W-1:0]  runs_q;
  logic [RUNS_W-1:0]  runs_done;
  logic [RC_W-1:0]    rst_cnt;
  logic [31:0]        wait_cnt;
  logic [31:0]        wait_limit;
  logic [RUNS_W:0]    runs_next;
  logic               accept;
  logic               done_stable;
  logic [BUS_WIDTH-1:0] go_word;

  logic                 busy_d;
  logic                 valid_d;
  logic                 rstn_d;
  logic [BUS_WIDTH-1:0] reg0_d;

  rp_done_sync u_done_sync (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .clr         (state != WAIT),
    .done_async  (rp_reg_1[GO_DONE_BIT]),
    .done_stable (done_stable)
  );

  always_comb begin
    go_word                = '0;
    go_word[GO_DONE_BIT]   = 1'b1;
    go_word[COUNT_W-1:0]   = win_q;
  end

  // 32-bit limit: a 31-bit window plus the margin cannot wrap.
  assign wait_limit = 32'(win_q) + 32'(TIMEOUT_MARGIN);
  assign runs_next  = {1'b0, runs_done} + {{RUNS_W{1'b0}}, 1'b1};
  assign accept     = (state == IDLE) && start;

  // Next state, then the output values that state_d will present once registered.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = RP_RST;
      RP_RST:  if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_d = ARM;
      ARM:     state_d = WAIT;
      // Done is checked first so it wins over a coincident timeout.
      WAIT: begin
        if (done_stable)               state_d = CAPTURE;
        else if (wait_cnt >= wait_limit) state_d = ERR;
      end
      CAPTURE: state_d = (runs_next == {1'b0, runs_q}) ? FINISH : RP_RST;
      FINISH:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == FINISH) || (state_d == ERR);
    rstn_d  = 1'b0;
    reg0_d  = '0;
    if (state_d == ARM || state_d == WAIT || state_d == CAPTURE) begin
      rstn_d = 1'b1;
      reg0_d = go_word;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
      rp_reset_n   <= 1'b0;
      rp_reg_0     <= '0;
      timeout_err  <= 1'b0;
      win_q        <= '0;
      runs_q       <= '0;
      runs_done    <= '0;
      rst_cnt      <= '0;
      wait_cnt     <= '0;
      result_sum   <= '0;
      last_count   <= '0;
    end else begin
      busy         <= busy_d;
      result_valid <= valid_d;
      rp_reset_n   <= rstn_d;
      rp_reg_0     <= reg0_d;

      if (accept) begin
        win_q       <= window;
        runs_q      <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
        runs_done   <= '0;
        result_sum  <= '0;
        timeout_err <= 1'b0;
      end

      if (state_d == ERR) begin
        timeout_err <= 1'b1;
      end

      if (state == RP_RST) begin
        rst_cnt <= rst_cnt + RC_W'(1);
      end else begin
        rst_cnt <= '0;
      end

      if (state == ARM) begin
        wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 32'd1;
      end

      // The partition freezes its count once done is set, so the word is stable here.
      if (state == CAPTURE) begin
        last_count <= rp_reg_1[COUNT_W-1:0];
        result_sum <= result_sum + SUM_W'(rp_reg_1[COUNT_W-1:0]);
        runs_done  <= runs_done + RUNS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rp_sequencer.sv
module tb_rp_sequencer;

  localparam int RUNS_W = 8;
  localparam int SUM_W  = 31 + RUNS_W;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic [30:0]       window = '0;
  logic [RUNS_W-1:0] num_runs = '0;
  logic              busy;
  logic              result_valid;
  logic [SUM_W-1:0]  result_sum;
  logic [30:0]       last_count;
  logic              timeout_err;
  logic [31:0]       rp_reg_0;
  logic [31:0]       rp_reg_1 = '0;
  logic              rp_reset_n;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [30:0]      last;
    logic             terr;
  } exp_t;

  exp_t exp_q[$];

  rp_sequencer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .window       (window),
    .num_runs     (num_runs),
    .busy         (busy),
    .result_valid (result_valid),
    .result_sum   (result_sum),
    .last_count   (last_count),
    .timeout_err  (timeout_err),
    .rp_reg_0     (rp_reg_0),
    .rp_reg_1     (rp_reg_1),
    .rp_reset_n   (rp_reset_n)
  );

  always #5 Clk = ~Clk;

  // Partition model: after go, reports done with the next queued count at window+10.
  logic [30:0] mdl_counts[$];
  bit          mdl_never_done = 1'b0;
  bit          mdl_manual     = 1'b0;
  int          mcnt = 0;

  always @(negedge Clk) begin
    if (!mdl_manual) begin
      if (!rp_reset_n) begin
        rp_reg_1 = '0;
        mcnt     = 0;
      end else if (rp_reg_0[31] && !rp_reg_1[31]) begin
        mcnt = mcnt + 1;
        if (!mdl_never_done && mcnt >= int'(rp_reg_0[30:0]) + 10) begin
          if (mdl_counts.size() > 0) rp_reg_1 = {1'b1, mdl_counts.pop_front()};
          else                       rp_reg_1 = 32'h8000_0000;
        end
      end
    end
  end

  task automatic do_start(input logic [30:0] w, input logic [RUNS_W-1:0] n);
    @(negedge Clk);
    start    = 1'b1;
    window   = w;
    num_runs = n;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (rp_reg_0[31]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (result_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    @(negedge Clk);
    n_tests++;
    if ({busy, result_valid, timeout_err, rp_reset_n} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy, result_valid, timeout_err, rp_reset_n});
    end
    n_tests++;
    if ({result_sum, last_count, rp_reg_0} !== '0) begin
      n_fail++; $display("FAIL reset_data: sum=%0h last=%0h reg0=%0h want all 0", result_sum, last_count, rp_reg_0);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit   ok;
    exp_t e;
    mdl_counts.push_back(31'd1000);
    exp_q.push_back('{sum: SUM_W'(1000), last: 31'd1000, terr: 1'b0});
    do_start(31'd100, 8'd1);
    wait_go(ok);
    n_tests++;
    if (!ok || rp_reg_0 !== 32'h8000_0064) begin
      n_fail++; $display("FAIL basic_arm_reg0: got %h want 80000064", rp_reg_0);
    end
    n_tests++;
    if (rp_reset_n !== 1'b1) begin
      n_fail++; $display("FAIL basic_arm_rstn: got %b want 1", rp_reset_n);
    end
    wait_rv(400, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL basic_result: got sum=%0d last=%0d terr=%b want sum=%0d last=%0d terr=%b",
                         result_sum, last_count, timeout_err, e.sum, e.last, e.terr);
    end
    @(negedge Clk);
    n_tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_single_pulse: got rv=%b busy=%b want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_multi_run();
    bit   ok;
    exp_t e;
    int   low_len;
    int   spans[$];
    mdl_counts.push_back(31'd500);
    mdl_counts.push_back(31'd600);
    mdl_counts.push_back(31'd700);
    exp_q.push_back('{sum: SUM_W'(1800), last: 31'd700, terr: 1'b0});
    do_start(31'd40, 8'd3);
    low_len = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (result_valid) begin ok = 1'b1; break; end
      if (!rp_reset_n) low_len++;
      else if (low_len > 0) begin spans.push_back(low_len); low_len = 0; end
    end
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL multi_result: got sum=%0d last=%0d terr=%b want sum=%0d last=%0d terr=%b",
                         result_sum, last_count, timeout_err, e.sum, e.last, e.terr);
    end
    n_tests++;
    if (spans.size() != 3) begin
      n_fail++; $display("FAIL multi_reset_spans: got %0d spans want 3", spans.size());
    end else begin
      n_tests++;
      if (spans[1] != 4 || spans[2] != 4) begin
        n_fail++; $display("FAIL multi_reset_len: got %0d,%0d want 4,4", spans[1], spans[2]);
      end
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    exp_t e;
    int   k;
    mdl_never_done = 1'b1;
    exp_q.push_back('{sum: '0, last: 31'd700, terr: 1'b1});
    do_start(31'd50, 8'd1);
    wait_go(ok);
    // ARM, then WAIT with wait_cnt 0..1074; ERR follows the cycle wait_cnt hits 50+1024.
    k = 0;
    while (ok && !timeout_err && k < 3000) begin
      @(negedge Clk);
      k++;
    end
    n_tests++;
    if (!ok || k != 1076) begin
      n_fail++; $display("FAIL timeout_delay: got %0d cycles want 1076", k);
    end
    n_tests++;
    if (result_valid !== 1'b1 || rp_reset_n !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_err_cycle: got rv=%b rstn=%b busy=%b want 1 0 1", result_valid, rp_reset_n, busy);
    end
    e = exp_q.pop_front();
    n_tests++;
    if ({result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL timeout_result: got sum=%0d last=%0d terr=%b want sum=%0d last=%0d terr=%b",
                         result_sum, last_count, timeout_err, e.sum, e.last, e.terr);
    end
    repeat (3) @(negedge Clk);
    n_tests++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_after: got busy=%b terr=%b rv=%b want 0 1 0", busy, timeout_err, result_valid);
    end
    mdl_never_done = 1'b0;
  endtask

  task automatic test_zero_runs();
    bit   ok;
    exp_t e;
    int   gos;
    logic prev_go;
    mdl_counts.push_back(31'd333);
    mdl_counts.push_back(31'd999);
    exp_q.push_back('{sum: SUM_W'(333), last: 31'd333, terr: 1'b0});
    do_start(31'd0, 8'd0);
    n_tests++;
    if (timeout_err !== 1'b0 || result_sum !== '0) begin
      n_fail++; $display("FAIL zero_start_clear: got terr=%b sum=%0d want 0 0", timeout_err, result_sum);
    end
    gos = 0;
    prev_go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (rp_reg_0[31] && !prev_go) gos++;
      prev_go = rp_reg_0[31];
      if (result_valid) begin ok = 1'b1; break; end
    end
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL zero_result: got sum=%0d last=%0d terr=%b want sum=%0d last=%0d terr=%b",
                         result_sum, last_count, timeout_err, e.sum, e.last, e.terr);
    end
    n_tests++;
    if (gos != 1) begin
      n_fail++; $display("FAIL zero_run_count: got %0d runs want 1", gos);
    end
    mdl_counts.delete();
  endtask

  task automatic test_mid_reset();
    bit ok;
    mdl_never_done = 1'b1;
    do_start(31'd1000, 8'd1);
    wait_go(ok);
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || {busy, result_valid, timeout_err, rp_reset_n} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b want 0000", {busy, result_valid, timeout_err, rp_reset_n});
    end
    n_tests++;
    if ({result_sum, last_count, rp_reg_0} !== '0) begin
      n_fail++; $display("FAIL midreset_data: sum=%0h last=%0h reg0=%0h want all 0", result_sum, last_count, rp_reg_0);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    mdl_never_done = 1'b0;
  endtask

  task automatic test_start_while_busy();
    bit   ok;
    exp_t e;
    int   bad;
    mdl_counts.push_back(31'd11);
    mdl_counts.push_back(31'd22);
    exp_q.push_back('{sum: SUM_W'(33), last: 31'd22, terr: 1'b0});
    do_start(31'd100, 8'd2);
    wait_go(ok);
    do_start(31'd7, 8'd1);
    bad = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge Clk);
      if (rp_reg_0[31] && rp_reg_0[30:0] != 31'd100) bad++;
      if (result_valid) break;
    end
    n_tests++;
    if (!ok || bad != 0) begin
      n_fail++; $display("FAIL busy_start_window: got %0d cycles with wrong window want 0", bad);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (result_valid !== 1'b1 || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL busy_start_result: got sum=%0d last=%0d rv=%b want sum=%0d last=%0d",
                         result_sum, last_count, result_valid, e.sum, e.last);
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    mdl_counts.push_back(31'd5);
    mdl_counts.push_back(31'd6);
    exp_q.push_back('{sum: SUM_W'(5), last: 31'd5, terr: 1'b0});
    exp_q.push_back('{sum: SUM_W'(6), last: 31'd6, terr: 1'b0});
    do_start(31'd30, 8'd1);
    wait_rv(400, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL b2b_first: got sum=%0d last=%0d want sum=%0d last=%0d", result_sum, last_count, e.sum, e.last);
    end
    // Start raised in the result_valid cycle: ignored there, taken once IDLE.
    start    = 1'b1;
    window   = 31'd40;
    num_runs = 8'd1;
    @(negedge Clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
    end
    @(negedge Clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || result_sum !== '0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b sum=%0d want 1 0", busy, result_sum);
    end
    wait_rv(400, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL b2b_second: got sum=%0d last=%0d want sum=%0d last=%0d", result_sum, last_count, e.sum, e.last);
    end
  endtask

  task automatic test_glitch();
    bit   ok;
    exp_t e;
    int   early;
    mdl_manual = 1'b1;
    rp_reg_1   = '0;
    exp_q.push_back('{sum: SUM_W'(4242), last: 31'd4242, terr: 1'b0});
    do_start(31'd20, 8'd1);
    wait_go(ok);
    repeat (5) @(negedge Clk);
    rp_reg_1 = {1'b1, 31'd77};
    @(negedge Clk);
    rp_reg_1 = '0;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (result_valid || !busy) early++;
    end
    n_tests++;
    if (!ok || early != 0) begin
      n_fail++; $display("FAIL glitch_ignored: got %0d early-end cycles want 0", early);
    end
    rp_reg_1 = {1'b1, 31'd4242};
    wait_rv(100, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || {result_sum, last_count, timeout_err} !== e) begin
      n_fail++; $display("FAIL glitch_result: got sum=%0d last=%0d terr=%b want sum=%0d last=%0d terr=%b",
                         result_sum, last_count, timeout_err, e.sum, e.last, e.terr);
    end
    rp_reg_1   = '0;
    mdl_manual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_run();
    test_timeout();
    test_zero_runs();
    test_mid_reset();
    test_start_while_busy();
    test_back_to_back();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rp_sequencer.md
Name: rp_sequencer

Overview:
- Initiator for the reconfigurable-partition measurement register interface.
- Drives rp_reg_0 (start bit plus window) and a partition reset, then waits for the done bit in rp_reg_1 and captures the 31-bit oscillation count.
- Repeats for num_runs runs, accumulates the counts and reports the sum to the host logic.
- Sits between the processor-side register block and the reconfigurable module slot.

Parameters:
- BUS_WIDTH, 32, width of the rp_reg_0 and rp_reg_1 buses.
- RUNS_W, 8, width of num_runs; the accumulator is 31+RUNS_W bits wide.
- RST_CYCLES, 4, Clk cycles that rp_reset_n is held low before each run.
- TIMEOUT_MARGIN, 1024, Clk cycles allowed beyond window before the run is declared dead.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset for this block; asynchronous, active-low.
- start  in  1  command; accepted only in IDLE; ignored otherwise.
- window  in  31  sample period in Clk cycles; latched on an accepted start.
- num_runs  in  RUNS_W  number of runs to accumulate; 0 is treated as 1; latched on start.
- busy  out  1  high from an accepted start until result_valid, inclusive.
- result_valid  out  1  one-cycle pulse when the sequence ends, normally or on error.
- result_sum  out  31+RUNS_W  sum of captured counts; held until the next accepted start.
- last_count  out  31  count from the most recent completed run.
- timeout_err  out  1  sticky; cleared on an accepted start.
- rp_reg_0  out  BUS_WIDTH  command word to the partition: bit31 = go, bits30:0 = window.
- rp_reg_1  in  BUS_WIDTH  status word from the partition: bit31 = done, bits30:0 = count.
- rp_reset_n  out  1  reset to the partition, driven by this block, active-low.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, result_valid=0, result_sum=0, last_count=0, timeout_err=0, rp_reg_0=0, rp_reset_n=0.
  - All counters are cleared.
- Done synchronizer: rp_reg_1[31] is asynchronous to Clk (it is produced in the oscillator domain) and passes through a 2-flop synchronizer. rp_reg_1[30:0] is sampled only after the synchronized done bit has been high for 2 consecutive Clk cycles. The partition freezes its count once done is set.
- IDLE:
  - rp_reset_n=0, rp_reg_0=0.
  - On start, latch window and num_runs, clear result_sum, runs_done and timeout_err, set busy, then go to RP_RST.
- RP_RST:
  - rp_reset_n=0 and rp_reg_0=0 for RST_CYCLES cycles, then go to ARM.
- ARM:
  - Release rp_reset_n (=1).
  - Drive rp_reg_0={1'b1, window}.
  - Clear wait_cnt, then go to WAIT next cycle.
- WAIT:
  - Hold rp_reg_0 and increment wait_cnt, which saturates.
  - After the 2-cycle stable synchronized done, go to CAPTURE.
  - If wait_cnt reaches window+TIMEOUT_MARGIN first, go to ERR. The comparison uses a 32-bit sum, so there is no wrap.
- CAPTURE (1 cycle):
  - last_count <= rp_reg_1[30:0].
  - result_sum <= result_sum + zero-extended count. There is no overflow by construction: at most 255 × (2^31−1).
  - runs_done+1.
  - If runs_done+1 equals the effective num_runs, go to FINISH; else go to RP_RST.
- FINISH:
  - Pulse result_valid, drop busy the next cycle, drive rp_reg_0=0, go to IDLE.
- ERR:
  - Set timeout_err, drive rp_reset_n=0 and rp_reg_0=0.
  - Pulse result_valid, go to IDLE.
  - result_sum holds the partial sum of the completed runs.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle that result_valid is asserted is ignored; it is accepted once IDLE is reached.
  - Done and timeout reached in the same cycle: done wins.
- window=0 is legal. The partition may report done immediately and a count of 0 is captured.
- Reset mid-sequence aborts immediately. rp_reset_n is forced low asynchronously, so the partition is cleared.
- Latency with no errors: per run, RST_CYCLES + 1 (ARM) + done latency + 2 (synchronizer) + 2 (stability check) + 1 (CAPTURE).

Decomposition:
- Package rp_pkg holds:
  - state encoding: IDLE, RP_RST, ARM, WAIT, CAPTURE, FINISH, ERR;
  - GO_DONE_BIT=31 and COUNT_W=31;
  - BUS_WIDTH default.
- One sub-module: rp_done_sync, a 2-flop synchronizer plus 2-cycle stability qualifier with an async active-low reset.

Test Plan:
- Behavioural partition model reports done at window+10 with count 1000; start, window=100, num_runs=1 -> rp_reg_0=0x80000064 in ARM; result_valid pulses once; result_sum=1000; last_count=1000; timeout_err=0.
- Model counts 500, 600, 700; num_runs=3 -> rp_reset_n low 4 cycles before each run; result_sum=1800; last_count=700.
- num_runs=0 -> exactly one run executes; result_sum equals that count.
- Model never sets done; window=50 -> timeout_err=1 at wait_cnt=1074; result_valid pulse; rp_reset_n=0; busy falls.
- Reset_n asserted mid-WAIT -> all outputs reach reset values without a Clk edge; start pulsed while busy -> no state change or relatch.
- Done bit toggles for 1 cycle only (glitch) -> no capture; a steady done 20 cycles later -> capture correct count.
